// File: rtl/led_sequencer.sv
// LED ownership controller: passes software LED value through, or runs a PWM-faded
// back-and-forth demo sweep and fades it out before handing the LEDs back.
module led_sequencer #(
    parameter int unsigned NLEDS       = 8,
    parameter int unsigned STEP_CYCLES = 2_500_000,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_demo,
    input  logic [NLEDS-1:0] i_sw_led,
    input  logic             i_btn_press,
    output logic [NLEDS-1:0] o_led,
    output logic             o_active
);
    localparam int unsigned POS_W = (NLEDS > 1) ? $clog2(NLEDS) : 1;
    localparam int unsigned PRE_W = $clog2(STEP_CYCLES);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NLEDS - 1);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] BMAX     = '1;

    typedef enum logic [1:0] {ST_SW, ST_DEMO, ST_FADE} state_e;

    state_e              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                down_q, down_d;
    logic [PWM_BITS-1:0] bright_q [NLEDS];
    logic [PWM_BITS-1:0] bright_d [NLEDS];
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [NLEDS-1:0]    led_q, led_d;
    logic                active_q, active_d;

    logic                tick;
    logic                all_dark;
    logic                down_eff;
    logic [NLEDS-1:0]    led_cmp;

    // Next-state, sweep, brightness and output mux.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        down_d   = down_q;
        bright_d = bright_q;
        presc_d  = presc_q;
        pwm_d    = pwm_q + PWM_BITS'(1);
        down_eff = down_q;
        all_dark = 1'b1;
        led_cmp  = '0;

        for (int i = 0; i < NLEDS; i++) begin
            if (bright_q[i] != '0) all_dark = 1'b0;
            led_cmp[i] = (bright_q[i] > pwm_q);
        end
        tick = (state_q != ST_SW) && (presc_q == PRE_LAST);

        case (state_q)
            ST_SW: begin
                if (i_demo) begin
                    state_d  = ST_DEMO;
                    pos_d    = '0;
                    down_d   = 1'b0;
                    bright_d = '{default: '0};
                end
            end
            ST_DEMO: if (!i_demo) state_d = ST_FADE;
            ST_FADE: begin
                if (i_demo)        state_d = ST_DEMO;
                else if (all_dark) state_d = ST_SW;
            end
            default: state_d = ST_SW;
        endcase

        // Button toggle lands before the step so the step sees the new direction.
        if (state_q == ST_DEMO) begin
            down_eff = down_q ^ i_btn_press;
            down_d   = down_eff;
            if (tick && (NLEDS > 1)) begin
                if (!down_eff) begin
                    if (pos_q != POS_LAST) begin
                        pos_d = pos_q + POS_W'(1);
                    end else begin
                        pos_d  = pos_q - POS_W'(1);
                        down_d = 1'b1;
                    end
                end else begin
                    if (pos_q != '0) begin
                        pos_d = pos_q - POS_W'(1);
                    end else begin
                        pos_d  = pos_q + POS_W'(1);
                        down_d = 1'b0;
                    end
                end
            end
        end

        if (tick) begin
            for (int i = 0; i < NLEDS; i++) begin
                bright_d[i] = (bright_q[i] != '0) ? bright_q[i] - PWM_BITS'(1) : '0;
                if ((state_q == ST_DEMO) && (POS_W'(i) == pos_q)) bright_d[i] = BMAX;
            end
        end

        if ((state_q == ST_SW) || (state_d == ST_SW)) presc_d = '0;
        else if (tick)                                presc_d = '0;
        else                                          presc_d = presc_q + PRE_W'(1);

        led_d    = (state_d == ST_SW) ? i_sw_led : led_cmp;
        active_d = (state_d != ST_SW);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_SW;
            pos_q    <= '0;
            down_q   <= 1'b0;
            bright_q <= '{default: '0};
            presc_q  <= '0;
            pwm_q    <= '0;
            led_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            down_q   <= down_d;
            bright_q <= bright_d;
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            led_q    <= led_d;
            active_q <= active_d;
        end
    end

    assign o_led    = led_q;
    assign o_active = active_q;

endmodule
